dual_wb_stage: RTL and testbench

- Dual-issue writeback stage.
- Registers the two retiring slots from MEM and performs load-data alignment and sign extension.
- Drives the register file's two write ports (inst1_*, inst2_*) with write-after-write (WAW) and r0 resolution already applied.
- Slot 1 is older than slot 2 in program order.
- Also provides retire and diagnostic counters for the debug/perf logic.

---
 rtl/wb_pkg.sv | 18 +
 rtl/load_ext.sv | 56 +++++
 rtl/dual_wb_stage.sv | 108 ++++++++++
 tb/tb_dual_wb_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the dual-issue writeback stage.
// Holds the default datapath widths and the load-op encoding that MEM uses
// on m*_ldop.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [2:0] ldop_t;

  localparam ldop_t LDOP_NONE = 3'd0;
  localparam ldop_t LDOP_LB   = 3'd1;
  localparam ldop_t LDOP_LBU  = 3'd2;
  localparam ldop_t LDOP_LH   = 3'd3;
  localparam ldop_t LDOP_LHU  = 3'd4;
  localparam ldop_t LDOP_LW   = 3'd5;

endpackage

// File: rtl/load_ext.sv
// Combinational load aligner / extender for one retiring slot.
// Ports:
//   data       raw ALU result or raw load word
//   ldop       load op (wb_pkg LDOP_*)
//   addr_lo    load address bits [1:0]
//   ext_data   aligned and extended result (pass-through for NONE/LW)
//   misaligned halfword on an odd address, or word on a non-zero offset
// ext_data is still produced for a misaligned load; the caller suppresses
// the write, so the value is only informational.
module load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = wb_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  ldop_t             ldop,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] ext_data,
  output logic              misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[7:0];
    case (addr_lo)
      2'd0: byte_sel = data[7:0];
      2'd1: byte_sel = data[15:8];
      2'd2: byte_sel = data[23:16];
      2'd3: byte_sel = data[31:24];
      default: byte_sel = data[7:0];
    endcase
    half_sel = addr_lo[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    ext_data   = data;
    misaligned = 1'b0;
    case (ldop)
      LDOP_LB:  ext_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LDOP_LBU: ext_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LDOP_LH: begin
        ext_data   = {{(DATA_W-16){half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      LDOP_LHU: begin
        ext_data   = {{(DATA_W-16){1'b0}}, half_sel};
        misaligned = addr_lo[0];
      end
      LDOP_LW:  misaligned = (addr_lo != 2'd0);
      default:  ext_data = data;
    endcase
  end

endmodule

// File: rtl/dual_wb_stage.sv
// Dual-issue writeback stage. Registers the two retiring MEM slots, aligns
// and extends load data, and drives the two register-file write ports with
// r0 suppression and same-cycle WAW resolution applied. Slot 1 is older.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   stall_in, flush         hazard hold / discard of the presented slots
//   mem_ready               stage can accept
//   m1_* / m2_*             retiring slots from MEM
//   inst1_* / inst2_*       register-file write ports (1-cycle latency)
//   misalign_err            one-cycle pulse: a misaligned load was dropped
//   retire_cnt, waw_cnt     retired instructions / resolved WAW collisions
// Handshake: a transfer happens on a posedge where mem_ready=1 and at least
// one m*_valid=1; MEM must hold nothing back since there is no backpressure
// beyond mem_ready, and each accepted slot produces exactly one write cycle.
module dual_wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall_in,
  input  logic              flush,
  output logic              mem_ready,
  input  logic              m1_valid,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_wa,
  input  logic [DATA_W-1:0] m1_data,
  input  logic [2:0]        m1_ldop,
  input  logic [1:0]        m1_addr_lo,
  input  logic              m2_valid,
  input  logic              m2_we,
  input  logic [ADDR_W-1:0] m2_wa,
  input  logic [DATA_W-1:0] m2_data,
  input  logic [2:0]        m2_ldop,
  input  logic [1:0]        m2_addr_lo,
  output logic              inst1_we,
  output logic [ADDR_W-1:0] inst1_wa,
  output logic [DATA_W-1:0] inst1_w2regdata,
  output logic              inst2_we,
  output logic [ADDR_W-1:0] inst2_wa,
  output logic [DATA_W-1:0] inst2_w2regdata,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [15:0]       waw_cnt
);

  logic [DATA_W-1:0] ext1, ext2;
  logic              mis1, mis2;
  logic              accept, capture;
  logic              gate1, gate2, waw_hit;

  load_ext #(.DATA_W(DATA_W)) u_ext1 (
    .data(m1_data), .ldop(m1_ldop), .addr_lo(m1_addr_lo),
    .ext_data(ext1), .misaligned(mis1)
  );

  load_ext #(.DATA_W(DATA_W)) u_ext2 (
    .data(m2_data), .ldop(m2_ldop), .addr_lo(m2_addr_lo),
    .ext_data(ext2), .misaligned(mis2)
  );

  // Held low during reset so every output reads 0 while resetn=0.
  assign mem_ready = resetn & ~stall_in;
  assign accept    = mem_ready & (m1_valid | m2_valid);
  // flush wins over accept: the presented slots are dropped and not counted.
  assign capture   = accept & ~flush;

  assign gate1   = m1_valid & m1_we & ~mis1 & (m1_wa != '0);
  assign gate2   = m2_valid & m2_we & ~mis2 & (m2_wa != '0);
  // Younger slot 2 wins a same-address collision.
  assign waw_hit = gate1 & gate2 & (m1_wa == m2_wa);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst1_we        <= 1'b0;
      inst1_wa        <= '0;
      inst1_w2regdata <= '0;
      inst2_we        <= 1'b0;
      inst2_wa        <= '0;
      inst2_w2regdata <= '0;
      misalign_err    <= 1'b0;
      retire_cnt      <= '0;
      waw_cnt         <= '0;
    end else if (capture) begin
      inst1_we        <= gate1 & ~waw_hit;
      inst1_wa        <= m1_wa;
      inst1_w2regdata <= ext1;
      inst2_we        <= gate2;
      inst2_wa        <= m2_wa;
      inst2_w2regdata <= ext2;
      misalign_err    <= (m1_valid & mis1) | (m2_valid & mis2);
      retire_cnt      <= retire_cnt + CNT_W'(m1_valid) + CNT_W'(m2_valid);
      if (waw_hit && (waw_cnt != '1)) begin
        waw_cnt <= waw_cnt + 16'd1;
      end
    end else begin
      // Bubble: writes last exactly one cycle; address/data fields keep the
      // last captured slot since the regfile ignores them with we=0.
      inst1_we     <= 1'b0;
      inst2_we     <= 1'b0;
      misalign_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dual_wb_stage.sv
module tb_dual_wb_stage;

  localparam int EXP_W = 1 + 5 + 32 + 1 + 5 + 32 + 1 + 32 + 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall_in = 1'b0, flush = 1'b0;
  logic        mem_ready;
  logic        m1_valid = 0, m1_we = 0, m2_valid = 0, m2_we = 0;
  logic [4:0]  m1_wa = 0, m2_wa = 0;
  logic [31:0] m1_data = 0, m2_data = 0;
  logic [2:0]  m1_ldop = 0, m2_ldop = 0;
  logic [1:0]  m1_addr_lo = 0, m2_addr_lo = 0;
  logic        inst1_we, inst2_we, misalign_err;
  logic [4:0]  inst1_wa, inst2_wa;
  logic [31:0] inst1_w2regdata, inst2_w2regdata, retire_cnt;
  logic [15:0] waw_cnt;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [EXP_W-1:0] exp_q[$];

  // model state
  logic [31:0] md_retire = 0;
  logic [15:0] md_waw = 0;
  logic [4:0]  md_wa1 = 0, md_wa2 = 0;
  logic [31:0] md_d1 = 0, md_d2 = 0;

  dual_wb_stage dut (
    .clk(clk), .resetn(resetn), .stall_in(stall_in), .flush(flush),
    .mem_ready(mem_ready),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_wa(m1_wa), .m1_data(m1_data),
    .m1_ldop(m1_ldop), .m1_addr_lo(m1_addr_lo),
    .m2_valid(m2_valid), .m2_we(m2_we), .m2_wa(m2_wa), .m2_data(m2_data),
    .m2_ldop(m2_ldop), .m2_addr_lo(m2_addr_lo),
    .inst1_we(inst1_we), .inst1_wa(inst1_wa), .inst1_w2regdata(inst1_w2regdata),
    .inst2_we(inst2_we), .inst2_wa(inst2_wa), .inst2_w2regdata(inst2_w2regdata),
    .misalign_err(misalign_err), .retire_cnt(retire_cnt), .waw_cnt(waw_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Load semantics from the ISA rules: pick the addressed byte/half, extend.
  function automatic logic [31:0] ext_model(input logic [31:0] d, input int op,
                                            input int lo, output bit mis);
    int unsigned b, h;
    mis = 0;
    case (op)
      1, 2: begin
        b = (d >> (8 * lo)) & 32'hFF;
        if (op == 1 && b >= 128) return b | 32'hFFFF_FF00;
        return b;
      end
      3, 4: begin
        mis = (lo % 2) == 1;
        h = (d >> (16 * (lo / 2))) & 32'hFFFF;
        if (op == 3 && h >= 32768) return h | 32'hFFFF_0000;
        return h;
      end
      5: begin
        mis = (lo != 0);
        return d;
      end
      default: return d;
    endcase
  endfunction

  // Called at a posedge: predicts the outputs that edge produces.
  task automatic model_push();
    bit mis1, mis2, w1, w2, mis_out;
    logic [31:0] e1, e2;
    w1 = 0; w2 = 0; mis_out = 0;
    if (!resetn) begin
      md_retire = 0; md_waw = 0;
      md_wa1 = 0; md_wa2 = 0; md_d1 = 0; md_d2 = 0;
    end else if (!stall_in && !flush && (m1_valid || m2_valid)) begin
      e1 = ext_model(m1_data, int'(m1_ldop), int'(m1_addr_lo), mis1);
      e2 = ext_model(m2_data, int'(m2_ldop), int'(m2_addr_lo), mis2);
      w1 = m1_valid && m1_we && !mis1 && m1_wa != 0;
      w2 = m2_valid && m2_we && !mis2 && m2_wa != 0;
      if (w1 && w2 && m1_wa == m2_wa) begin
        w1 = 0;
        if (md_waw != 16'hFFFF) md_waw = md_waw + 1;
      end
      mis_out = (m1_valid && mis1) || (m2_valid && mis2);
      md_retire = md_retire + 32'(m1_valid) + 32'(m2_valid);
      md_wa1 = m1_wa; md_wa2 = m2_wa; md_d1 = e1; md_d2 = e2;
    end
    exp_q.push_back({w1, md_wa1, md_d1, w2, md_wa2, md_d2, mis_out, md_retire, md_waw});
  endtask

  // compare process
  always @(posedge clk) begin
    logic [EXP_W-1:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("inst1_we", 32'(inst1_we), 32'(e[124]));
      chk("inst1_wa", 32'(inst1_wa), 32'(e[123:119]));
      chk("inst1_data", inst1_w2regdata, e[118:87]);
      chk("inst2_we", 32'(inst2_we), 32'(e[86]));
      chk("inst2_wa", 32'(inst2_wa), 32'(e[85:81]));
      chk("inst2_data", inst2_w2regdata, e[80:49]);
      chk("misalign_err", 32'(misalign_err), 32'(e[48]));
      chk("retire_cnt", retire_cnt, e[47:16]);
      chk("waw_cnt", 32'(waw_cnt), 32'(e[15:0]));
      if (resetn) chk("mem_ready", 32'(mem_ready), 32'(!stall_in));
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_push();
    #1;
  endtask

  task automatic idle();
    m1_valid = 0; m1_we = 0; m2_valid = 0; m2_we = 0;
    stall_in = 0; flush = 0;
  endtask

  task automatic set_s1(input logic v, input logic we, input logic [4:0] wa,
                        input logic [31:0] d, input logic [2:0] op, input logic [1:0] lo);
    m1_valid = v; m1_we = we; m1_wa = wa; m1_data = d; m1_ldop = op; m1_addr_lo = lo;
  endtask

  task automatic set_s2(input logic v, input logic we, input logic [4:0] wa,
                        input logic [31:0] d, input logic [2:0] op, input logic [1:0] lo);
    m2_valid = v; m2_we = we; m2_wa = wa; m2_data = d; m2_ldop = op; m2_addr_lo = lo;
  endtask

  initial begin
    idle();
    #1;
    chk("rst_inst1_we", 32'(inst1_we), 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_waw", 32'(waw_cnt), 0);
    repeat (3) cycle();
    resetn = 1'b1;
    repeat (2) cycle();

    // S1: single ALU write
    set_s1(1, 1, 5'd3, 32'h1234, 3'd0, 2'd0);
    cycle(); idle(); #2;
    chk("s1_we1", 32'(inst1_we), 1);
    chk("s1_wa1", 32'(inst1_wa), 3);
    chk("s1_data1", inst1_w2regdata, 32'h1234);
    chk("s1_we2", 32'(inst2_we), 0);
    chk("s1_retire", retire_cnt, 1);
    cycle(); #2;
    chk("s1_one_cycle", 32'(inst1_we), 0);

    // S2: same-cycle WAW
    set_s1(1, 1, 5'd7, 32'hA, 3'd0, 2'd0);
    set_s2(1, 1, 5'd7, 32'hB, 3'd0, 2'd0);
    cycle(); idle(); #2;
    chk("s2_we1", 32'(inst1_we), 0);
    chk("s2_we2", 32'(inst2_we), 1);
    chk("s2_data2", inst2_w2regdata, 32'hB);
    chk("s2_waw", 32'(waw_cnt), 1);
    chk("s2_retire", retire_cnt, 3);

    // S3: load extension
    set_s1(1, 1, 5'd4, 32'h0080_FF00, 3'd2, 2'd2);
    set_s2(1, 1, 5'd5, 32'h8001_0000, 3'd4, 2'd2);
    cycle(); idle(); #2;
    chk("s3_lbu", inst1_w2regdata, 32'h0000_0080);
    chk("s3_lhu", inst2_w2regdata, 32'h0000_8001);
    set_s1(1, 1, 5'd4, 32'h0000_8000, 3'd1, 2'd1);
    cycle(); idle(); #2;
    chk("s3_lb_sext", inst1_w2regdata, 32'hFFFF_FF80);
    chk("s3_retire", retire_cnt, 6);

    // S4: misaligned LW and r0 write
    set_s1(1, 1, 5'd6, 32'hDEAD_BEEF, 3'd5, 2'd1);
    set_s2(1, 1, 5'd0, 32'h55, 3'd0, 2'd0);
    cycle(); idle(); #2;
    chk("s4_mis", 32'(misalign_err), 1);
    chk("s4_we1", 32'(inst1_we), 0);
    chk("s4_we2_r0", 32'(inst2_we), 0);
    chk("s4_retire", retire_cnt, 8);
    cycle(); #2;
    chk("s4_mis_pulse", 32'(misalign_err), 0);

    // S5: flush then stall
    set_s1(1, 1, 5'd9, 32'h99, 3'd0, 2'd0);
    set_s2(1, 1, 5'd10, 32'hAA, 3'd0, 2'd0);
    flush = 1;
    cycle(); flush = 0; stall_in = 1; #1;
    chk("s5_flush_we1", 32'(inst1_we), 0);
    chk("s5_flush_retire", retire_cnt, 8);
    chk("s5_stall_ready", 32'(mem_ready), 0);
    cycle(); idle(); #2;
    chk("s5_stall_we2", 32'(inst2_we), 0);
    chk("s5_stall_retire", retire_cnt, 8);

    // S6: reset mid-write
    set_s1(1, 1, 5'd3, 32'h1234, 3'd0, 2'd0);
    cycle(); idle(); #2;
    chk("s6_pre_we1", 32'(inst1_we), 1);
    resetn = 0; #1;
    chk("s6_async_we1", 32'(inst1_we), 0);
    chk("s6_async_data1", inst1_w2regdata, 0);
    chk("s6_async_retire", retire_cnt, 0);
    chk("s6_async_waw", 32'(waw_cnt), 0);
    cycle();
    resetn = 1;
    cycle();
    set_s1(1, 1, 5'd3, 32'h1234, 3'd0, 2'd0);
    cycle(); idle(); #2;
    chk("s6_after_we1", 32'(inst1_we), 1);
    chk("s6_after_data1", inst1_w2regdata, 32'h1234);
    chk("s6_after_retire", retire_cnt, 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      set_s1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 7)), $urandom,
             3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
      set_s2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 7)), $urandom,
             3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
      stall_in = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      cycle();
    end
    idle();
    repeat (3) cycle();
    @(posedge clk); #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
